// File: rtl/uart_pkg.sv
// uart_pkg: types and line-level constants shared by the UART transmitter
// and, later, the matching receiver.
//   tx_state_t : transmitter frame state
//   LINE_IDLE / START_BIT / STOP_BIT : serial line levels
//   cnt_width() : width of a counter that must hold 0..n-1 (never below 1)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: word handshake between a producer and the UART transmitter.
//   word              : data word offered for transmission
//   word_valid        : word holds a frame request
//   word_ready        : transmitter accepts word this cycle
//   connection_status : link up; while low no new frame is started
// master = producer side, slave = transmitter side.
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] word;
    logic              word_valid;
    logic              word_ready;
    logic              connection_status;

    modport master (
        output word, word_valid, connection_status,
        input  word_ready
    );

    modport slave (
        input  word, word_valid, connection_status,
        output word_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable; the counter is held at 0 while low
//   tick     : high on the last clock of each bit period
// With CLKS_PER_BIT=1 the counter never leaves 0, so tick simply follows en.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int               CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!en || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    assign tick = en && (cnt == LAST);
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Frame: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS
// stop bits; every bit lasts CLKS_PER_BIT clocks.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of the word handshake (word/valid/ready/connection)
//   txd      : serial line, idle high
//   busy     : frame in progress
// A word is accepted only in IDLE, so back-to-back frames are separated by
// one idle clock. txd is decoded from the state register so an asynchronous
// reset drives the line high at once.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_param_if.slave  bus,
    output logic            txd,
    output logic            busy
);
    generate
        if (DATA_W < 5 || DATA_W > 16) begin : g_bad_data_w
            $error("uart_tx_param: DATA_W must be 5..16");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 1) begin : g_bad_clks
            $error("uart_tx_param: CLKS_PER_BIT must be >= 1");
        end
    endgenerate

    localparam int               BIT_W     = cnt_width(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic              stop_cnt;
    logic              parity_bit;
    logic              tick;
    logic              accept;

    // Ready follows connection_status combinationally so a valid word and a
    // rising link are accepted in the same cycle.
    assign bus.word_ready = (state == IDLE) && bus.connection_status && !rst;
    assign accept         = bus.word_valid && bus.word_ready;
    assign busy           = (state != IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Word and its parity are captured at acceptance; later changes on the
    // bus do not reach the frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
        end else if (accept) begin
            shift_reg  <= bus.word;
            parity_bit <= (PARITY_ODD != 0) ? ~^bus.word : ^bus.word;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
        end else if (tick) begin
            case (state)
                DATA: begin
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
                end
                STOP:    stop_cnt <= ~stop_cnt;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        txd       = LINE_IDLE;
        case (state)
            IDLE: begin
                if (accept) state_nxt = START;
            end
            START: begin
                txd = START_BIT;
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                txd = shift_reg[0];
                if (tick && bit_cnt == LAST_BIT)
                    state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                txd = parity_bit;
                if (tick) state_nxt = STOP;
            end
            STOP: begin
                txd = STOP_BIT;
                if (tick && stop_cnt == LAST_STOP) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
